// File: rtl/hazard_scheduler.sv
// Scoreboard issue controller beside ID: RAW bubbles, branch flush and a stall counter.
// Optional macro HAZARD_SCHEDULER_FORWARDING_EN: writer latency becomes 1 for loads, 0 otherwise.
module hazard_scheduler #(
  parameter int WB_LAT = 3,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [4:0]        id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  output logic              issue,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [PERF_W-1:0] stall_count
);

  logic [CNT_W-1:0]  pending_r [1:31];
  logic [31:0]       busy_s;
  logic [CNT_W-1:0]  lat_s;
  logic              hazard_s;
  logic              flush_s;
  logic              stall_s;
  logic              issue_s;
  logic              mark_s;
  logic [PERF_W-1:0] stall_count_r;

  // Busy map of the scoreboard; bit 0 stays clear so x0 never blocks a reader.
  always_comb begin
    busy_s = 32'd0;
    for (int i = 1; i < 32; i++) begin
      busy_s[i] = (pending_r[i] != {CNT_W{1'b0}});
    end
  end

  // RAW check; a register used as both sources simply ORs to the same hazard.
  always_comb begin
    hazard_s = (id_rs1_used & busy_s[id_rs1]) | (id_rs2_used & busy_s[id_rs2]);
  end

`ifdef HAZARD_SCHEDULER_FORWARDING_EN
  // With EX/MEM->EX forwarding only a load leaves a one-cycle gap.
  always_comb begin
    if (id_is_load) begin
      lat_s = CNT_W'(32'd1);
    end else begin
      lat_s = {CNT_W{1'b0}};
    end
  end
`else
  logic unused_is_load_s;
  assign unused_is_load_s = id_is_load;
  assign lat_s            = CNT_W'(WB_LAT);
`endif

  // Issue decision; a taken branch squashes ID regardless of any hazard.
  always_comb begin
    if (reset) begin
      flush_s = 1'b0;
      stall_s = 1'b0;
      issue_s = 1'b0;
    end else begin
      flush_s = ex_branch_taken;
      stall_s = id_valid & hazard_s & ~ex_branch_taken;
      issue_s = id_valid & ~hazard_s & ~ex_branch_taken;
    end
    mark_s = issue_s & id_rd_we & (id_rd != 5'd0);
  end

  // Scoreboard counters: a fresh issue reloads its rd, everything else counts down.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        pending_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (mark_s && (id_rd == 5'(i))) begin
          pending_r[i] <= lat_s;
        end else if (pending_r[i] != {CNT_W{1'b0}}) begin
          pending_r[i] <= pending_r[i] - CNT_W'(32'd1);
        end else begin
          pending_r[i] <= pending_r[i];
        end
      end
    end
  end

  // Free-running stall performance counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_r <= {PERF_W{1'b0}};
    end else if (stall_s) begin
      stall_count_r <= stall_count_r + PERF_W'(32'd1);
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign issue       = issue_s;
  assign stall       = stall_s;
  assign bubble      = stall_s;
  assign flush       = flush_s;
  assign stall_count = stall_count_r;

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Scoreboard-based issue controller for the 5-stage RISC-V pipeline. Sits beside the ID stage.
- Decides each cycle whether the decoded instruction may move ID->EX, inserts bubbles on RAW hazards, and flushes on taken branches.
- Removes the need to hand-space dependent instructions in instruction memory.

Parameters:
- WB_LAT, 3, cycles from an issue until its rd is readable by a consumer in ID (no forwarding; register file is write-before-read)
- CNT_W, 2, width of each per-register pending counter; must satisfy 2^CNT_W-1 >= WB_LAT
- PERF_W, 32, width of the stall performance counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a valid instruction
- id_rs1  in  5  source register 1 index
- id_rs2  in  5  source register 2 index
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd  in  5  destination index
- id_rd_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- issue  out  1  ID instruction advances to EX this cycle
- stall  out  1  hold PC and IF/ID register
- bubble  out  1  load NOP into ID/EX
- flush  out  1  clear IF/ID and ID/EX (squash wrong-path)
- stall_count  out  PERF_W  cycles with stall=1 since reset, wraps

Behaviour:
- State: pending[1..31], each CNT_W bits; x0 has no entry and is never pending.
- hazard = (id_rs1_used & id_rs1!=0 & pending[id_rs1]!=0) | (id_rs2_used & id_rs2!=0 & pending[id_rs2]!=0).
- Outputs are combinational from inputs and state:
  - flush = ex_branch_taken.
  - stall = id_valid & hazard & ~flush.
  - bubble = stall.
  - issue = id_valid & ~hazard & ~flush.
- Every clock edge, each nonzero pending decrements by 1.
- If issue & id_rd_we & id_rd!=0, pending[id_rd] <= lat. This set wins over the decrement on the same register.
- lat = WB_LAT, default build.
- Timing: a producer issuing at cycle t makes its rd busy for t+1..t+3, so a dependent consumer issues at t+4. Back-to-back RAW therefore costs exactly WB_LAT=3 bubbles.
- Flush priority: flush overrides hazard. The flushed ID instruction never issues and never marks the scoreboard. Existing pending entries keep counting, because older instructions in MEM/WB still complete.
- Same register as both sources: counts as one hazard, with the same stall length.
- WAW: a new issue overwrites the counter with the fresh latency. In-order writeback keeps this correct.
- stall_count increments on every cycle with stall=1 and wraps to 0 after all ones.
- Reset: all pending <= 0 and stall_count <= 0. While reset=1, issue, stall, bubble and flush are forced to 0. Reset mid-stall aborts the stall on the next cycle.
- id_valid=0: issue=0, stall=0, bubble=0; counters still decrement.

Optional Feature:
- Macro: HAZARD_SCHEDULER_FORWARDING_EN.
- When defined, the datapath has EX/MEM->EX forwarding:
  - lat = 1 for loads (id_is_load=1), giving one load-use bubble.
  - lat = 0 for all other writers, giving no stall.
- When undefined, lat = WB_LAT for all writers and id_is_load is ignored.

Test Plan:
- addi x5,x0,8 then add x7,x5,x4 back-to-back, id_valid held -> stall=1 for exactly 3 cycles, issue of add on the 4th cycle, stall_count=3.
- addi x4 then 3 independent instructions, then add x7,x5,x4 -> stall never asserts, stall_count=0.
- Hazard pending on x10 while ex_branch_taken=1 (beq x4,x4,-140) -> flush=1, stall=0, issue=0, x10 counter continues toward 0, and no new scoreboard entry is made.
- Instructions writing x0 (addi x0,x0,0) followed by a reader of x0 -> no stall.
- reset asserted in 2nd stall cycle of an x7 RAW -> next cycle stall=0, pending all 0, stall_count=0, and the consumer issues immediately.
- With HAZARD_SCHEDULER_FORWARDING_EN: lw x15,4(x0) then add x30,x15,x16 -> exactly 1 bubble; addi x8 then sub x10,x7,x8 -> 0 bubbles.
